serial_pattern_tx: RTL and testbench
====================================

Name: serial_pattern_tx

Overview:
- Serial bit-pattern transmitter: loads a parallel pattern and shifts it out one bit per clock, MSB-first, on a single-bit line with a valid qualifier.
- Optional repeat count with idle gap cycles between repeats; start/busy/done handshake, abort input.
- Drives test sequences into the lab's serial sequence-detector FSMs; board wrapper maps SW/KEY/LEDR as usual (not part of this block).

Parameters:
- WIDTH, 8, maximum pattern length in bits.
- LEN_W, 4, width of length input; must hold WIDTH.
- GAP_CYCLES, 1, idle cycles between repeats; 0 = back-to-back repeats.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  request transmission; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE, no done.
- pattern  in  WIDTH  bits to send; bit [len-1] sent first.
- length  in  LEN_W  bits to send; 0 or >WIDTH treated as WIDTH.
- reps  in  4  extra repeats; total transmissions = reps+1.
- w_out  out  1  serial data; 0 whenever w_valid=0.
- w_valid  out  1  high for each cycle a pattern bit is on w_out.
- busy  out  1  high in SHIFT and GAP.
- done  out  1  one-cycle pulse after final bit of final repeat.
- state  out  3  current state code, for LEDR debug.

Behaviour:
- Reset (resetn=0 at edge): state IDLE; all outputs 0; shift reg, bit/gap/rep counters cleared. Reset mid-operation → outputs 0 at that edge, no done.
- States (3-bit): IDLE=000, SHIFT=001, GAP=010, DONE=011; other codes → IDLE next edge.
- IDLE: start=1 at edge → capture len_eff (clamped), reps, load shreg = pattern << (WIDTH-len_eff), bit_cnt=0, rep_cnt=0, go SHIFT. start=0 → stay.
- Latency: start sampled at edge k → first bit valid during cycle after edge k.
- SHIFT: w_valid=1, w_out=shreg[WIDTH-1]; each edge shift left 1, bit_cnt+1. At bit_cnt==len_eff-1: if rep_cnt<reps → rep_cnt+1, reload shreg from captured pattern, go GAP (or SHIFT directly if GAP_CYCLES=0); else → DONE.
- GAP: w_valid=0, w_out=0, busy=1; stay GAP_CYCLES cycles, then SHIFT with bit_cnt=0.
- DONE: done=1, busy=0, one cycle, then IDLE unconditionally; start in DONE ignored.
- Pattern/length/reps captured at start; input changes while busy are ignored. start while busy ignored.
- abort=1 in SHIFT/GAP/DONE → IDLE next edge, outputs 0, no done. resetn has priority over abort; abort over start.
- Outputs are Moore: combinational decode of registered state and shreg only; no input-to-output paths.
- Counters: bit_cnt LEN_W bits, rep_cnt 4 bits, gap_cnt sized for GAP_CYCLES; no wrap possible within legal ranges.

Decomposition:
- Shared include (seq_defs.vh): state codes IDLE/SHIFT/GAP/DONE, shared with detector benches for state decode.
- One sub-module: pattern_shreg (WIDTH-bit parallel-load, left-shift register with load/shift enables, MSB output). FSM and counters in top.

Test Plan:
- Reset: resetn=0 for 2 cycles with start=1 → state=000, w_out/w_valid/busy/done=0 throughout.
- pattern=8'hB5, length=0, reps=0 → w_out 1,0,1,1,0,1,0,1 over 8 valid cycles starting cycle after start; done=1 on cycle 9 only; busy cycles 1–8.
- pattern=8'h0D, length=4, reps=2, GAP_CYCLES=1 → 1101,gap,1101,gap,1101; w_valid low only in 2 gap cycles; busy 14 cycles; done on cycle 15.
- Mid-SHIFT start=1 with pattern=8'hFF → ignored; stream unchanged; later start in DONE also ignored.
- abort=1 at 3rd bit of 8'hB5 → next cycle state=000, w_valid=0, done never asserted; new start accepted immediately.
- length=9, pattern=8'h81 → clamped to 8, stream 1,0,0,0,0,0,0,1; resetn=0 at bit 5 → all outputs 0 next cycle.

Source files
------------

// File: rtl/serial_pattern_tx_pkg.sv
// ============================================================================
// serial_pattern_tx_pkg : state codes and helpers shared by the pattern TX
// Revision: 1.0
// ============================================================================
`default_nettype none

package serial_pattern_tx_pkg;

  // Codes are fixed so detector benches can decode the debug state bus.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_SHIFT = 3'b001,
    ST_GAP   = 3'b010,
    ST_DONE  = 3'b011
  } state_e;

  localparam int unsigned REPS_W = 4;

  // Zero or oversized lengths fall back to the full register width.
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned width);
    return ((len == 0) || (len > width)) ? width : len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_pattern_tx_if.sv
// ============================================================================
// serial_pattern_tx_if : control/stream bundle of the serial pattern TX
// Revision: 1.0
// ============================================================================
`default_nettype none

interface serial_pattern_tx_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
);
  logic                                      start;
  logic                                      abort;
  logic [WIDTH-1:0]                          pattern;
  logic [LEN_W-1:0]                          length;
  logic [serial_pattern_tx_pkg::REPS_W-1:0]  reps;
  logic                                      w_out;
  logic                                      w_valid;
  logic                                      busy;
  logic                                      done;
  logic [2:0]                                state;

  modport master (
    output start, abort, pattern, length, reps,
    input  w_out, w_valid, busy, done, state
  );

  modport slave (
    input  start, abort, pattern, length, reps,
    output w_out, w_valid, busy, done, state
  );
endinterface

`default_nettype wire

// File: rtl/serial_pattern_tx_pattern_shreg.sv
// ============================================================================
// serial_pattern_tx_pattern_shreg : parallel-load, left-shift register, MSB out
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_pattern_tx_pattern_shreg #(
  parameter int WIDTH = 8
) (
  input  wire logic             clock,
  input  wire logic             resetn,
  input  wire logic             load,
  input  wire logic             shift,
  input  wire logic [WIDTH-1:0] load_val,
  output logic                  msb
);
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = load_val;
    end else if (shift) begin
      shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign msb = shreg_q[WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/serial_pattern_tx.sv
// ============================================================================
// serial_pattern_tx : MSB-first serial pattern transmitter with repeats/gaps
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_pattern_tx
  import serial_pattern_tx_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LEN_W      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  wire logic          clock,
  input  wire logic          resetn,
  serial_pattern_tx_if.slave bus
);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  state_e              state_q,   state_d;
  logic [LEN_W-1:0]    len_q,     len_d;
  logic [REPS_W-1:0]   reps_q,    reps_d;
  logic [WIDTH-1:0]    pat_q,     pat_d;
  logic [LEN_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [REPS_W-1:0]   rep_cnt_q, rep_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;

  logic                sh_load;
  logic                sh_shift;
  logic [WIDTH-1:0]    sh_load_val;
  logic                sh_msb;
  logic [LEN_W-1:0]    len_in;
  logic [WIDTH-1:0]    pat_aligned;

  // Left-justify the pattern so bit [len-1] sits at the shift-out MSB.
  assign len_in      = LEN_W'(eff_len(32'(bus.length), WIDTH));
  assign pat_aligned = bus.pattern << (LEN_W'(WIDTH) - len_in);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    reps_d      = reps_q;
    pat_d       = pat_q;
    bit_cnt_d   = bit_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    sh_load     = 1'b0;
    sh_shift    = 1'b0;
    sh_load_val = pat_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          len_d       = len_in;
          reps_d      = bus.reps;
          pat_d       = pat_aligned;
          sh_load     = 1'b1;
          sh_load_val = pat_aligned;
          bit_cnt_d   = '0;
          rep_cnt_d   = '0;
          gap_cnt_d   = '0;
          state_d     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_q == (len_q - LEN_W'(1))) begin
          bit_cnt_d = '0;
          if (rep_cnt_q < reps_q) begin
            rep_cnt_d = rep_cnt_q + REPS_W'(1);
            sh_load   = 1'b1;
            gap_cnt_d = '0;
            state_d   = (GAP_CYCLES == 0) ? ST_SHIFT : ST_GAP;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          sh_shift  = 1'b1;
          bit_cnt_d = bit_cnt_q + LEN_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over everything except reset, including a start in IDLE.
    if (bus.abort) begin
      state_d   = ST_IDLE;
      sh_load   = 1'b0;
      sh_shift  = 1'b0;
      bit_cnt_d = '0;
      rep_cnt_d = '0;
      gap_cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      reps_q    <= '0;
      pat_q     <= '0;
      bit_cnt_q <= '0;
      rep_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      reps_q    <= reps_d;
      pat_q     <= pat_d;
      bit_cnt_q <= bit_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  serial_pattern_tx_pattern_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .clock    (clock),
    .resetn   (resetn),
    .load     (sh_load),
    .shift    (sh_shift),
    .load_val (sh_load_val),
    .msb      (sh_msb)
  );

  assign bus.w_valid = (state_q == ST_SHIFT);
  assign bus.w_out   = bus.w_valid & sh_msb;
  assign bus.busy    = (state_q == ST_SHIFT) || (state_q == ST_GAP);
  assign bus.done    = (state_q == ST_DONE);
  assign bus.state   = state_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_pattern_tx.sv
// ============================================================================
// tb_serial_pattern_tx : scoreboard bench for the serial pattern transmitter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serial_pattern_tx;
  localparam int WIDTH = 8;
  localparam int LEN_W = 4;
  localparam int GAP   = 1;

  // Observation word: {w_valid, w_out, busy, done, state}
  typedef struct packed {
    logic       valid;
    logic       dout;
    logic       busy;
    logic       done;
    logic [2:0] st;
  } obs_t;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  serial_pattern_tx_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

  serial_pattern_tx #(
    .WIDTH      (WIDTH),
    .LEN_W      (LEN_W),
    .GAP_CYCLES (GAP)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clock = ~clock;

  obs_t sb[$];
  int   checks = 0;
  int   errors = 0;
  localparam obs_t IDLE_OBS = 7'b0;

  task automatic step(output obs_t o);
    @(posedge clock);
    #1;
    o = {bus.w_valid, bus.w_out, bus.busy, bus.done, bus.state};
  endtask

  function automatic obs_t mk(logic v, logic d, logic b, logic dn, logic [2:0] s);
    return {v, d, b, dn, s};
  endfunction

  // Reference trace: one entry per cycle from the first bit to the idle after done.
  task automatic push_trace(input logic [WIDTH-1:0] pat, input int len, input int reps);
    int l;
    l = ((len == 0) || (len > WIDTH)) ? WIDTH : len;
    for (int r = 0; r <= reps; r++) begin
      for (int i = l - 1; i >= 0; i--) sb.push_back(mk(1'b1, pat[i], 1'b1, 1'b0, 3'b001));
      if (r < reps) for (int g = 0; g < GAP; g++) sb.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 3'b010));
    end
    sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 3'b011));
    sb.push_back(IDLE_OBS);
  endtask

  task automatic drive_start(input logic [WIDTH-1:0] pat, input int len, input int reps);
    bus.pattern = pat;
    bus.length  = LEN_W'(len);
    bus.reps    = 4'(reps);
    bus.start   = 1'b1;
    push_trace(pat, len, reps);
  endtask

  task automatic test_reset();
    obs_t o;
    bus.start = 1'b1; bus.abort = 1'b0; bus.pattern = 8'hFF; bus.length = 4'd8; bus.reps = 4'd3;
    resetn = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step(o);
      checks++;
      if (o !== IDLE_OBS) begin
        errors++;
        $display("FAIL reset cycle %0d: got {v,o,busy,done,st}=%b required %b", c, o, IDLE_OBS);
      end
    end
    bus.start = 1'b0;
    resetn = 1'b1;
    step(o);
    checks++;
    if (o !== IDLE_OBS) begin
      errors++;
      $display("FAIL reset_release: got %b required %b", o, IDLE_OBS);
    end
  endtask

  task automatic test_full_width();
    obs_t o, e;
    int cyc = 0;
    drive_start(8'hB5, 0, 0);
    while (sb.size() > 0) begin
      step(o);
      bus.start = 1'b0;
      e = sb.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL full_width cycle %0d: got %b required %b", cyc, o, e);
      end
      cyc++;
    end
  endtask

  task automatic test_repeat_gap();
    obs_t o, e;
    logic [WIDTH-1:0] pats[2] = '{8'h0D, 8'h01};
    int lens[2] = '{4, 1};
    int rps[2]  = '{2, 1};
    for (int t = 0; t < 2; t++) begin
      int cyc = 0;
      drive_start(pats[t], lens[t], rps[t]);
      while (sb.size() > 0) begin
        step(o);
        bus.start = 1'b0;
        e = sb.pop_front();
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL repeat_gap[%0d] cycle %0d: got %b required %b", t, cyc, o, e);
        end
        cyc++;
      end
    end
  endtask

  task automatic test_start_while_busy();
    obs_t o, e;
    int cyc = 0;
    drive_start(8'hB5, 0, 0);
    while (sb.size() > 0) begin
      step(o);
      e = sb.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL start_while_busy cycle %0d: got %b required %b", cyc, o, e);
      end
      // Hold a conflicting request through SHIFT and into DONE.
      if (cyc >= 1 && cyc <= 8) begin
        bus.start = 1'b1; bus.pattern = 8'hFF; bus.length = 4'd3; bus.reps = 4'd5;
      end else begin
        bus.start = 1'b0;
      end
      cyc++;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_abort();
    obs_t o, e;
    int cyc = 0;
    drive_start(8'hB5, 0, 0);
    for (int c = 0; c < 3; c++) begin
      step(o);
      bus.start = 1'b0;
      e = sb.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL abort_pre cycle %0d: got %b required %b", c, o, e);
      end
    end
    sb.delete();
    bus.abort = 1'b1;
    step(o);
    checks++;
    if (o !== IDLE_OBS) begin
      errors++;
      $display("FAIL abort_idle: got %b required %b", o, IDLE_OBS);
    end
    // Abort outranks a simultaneous start in IDLE.
    bus.start = 1'b1;
    step(o);
    checks++;
    if (o !== IDLE_OBS) begin
      errors++;
      $display("FAIL abort_over_start: got %b required %b", o, IDLE_OBS);
    end
    bus.abort = 1'b0;
    drive_start(8'h06, 3, 1);
    while (sb.size() > 0) begin
      step(o);
      bus.start = 1'b0;
      e = sb.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL abort_restart cycle %0d: got %b required %b", cyc, o, e);
      end
      cyc++;
    end
  endtask

  task automatic test_clamp_reset();
    obs_t o, e;
    drive_start(8'h81, 9, 0);
    for (int c = 0; c < 5; c++) begin
      step(o);
      bus.start = 1'b0;
      e = sb.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL clamp cycle %0d: got %b required %b", c, o, e);
      end
    end
    sb.delete();
    resetn = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step(o);
      checks++;
      if (o !== IDLE_OBS) begin
        errors++;
        $display("FAIL mid_reset cycle %0d: got %b required %b", c, o, IDLE_OBS);
      end
    end
    resetn = 1'b1;
    step(o);
    checks++;
    if (o !== IDLE_OBS) begin
      errors++;
      $display("FAIL post_reset_idle: got %b required %b", o, IDLE_OBS);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_width();
    test_repeat_gap();
    test_start_while_busy();
    test_abort();
    test_clamp_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
